// File: rtl/alu16_pipe_if.sv
// rtl/alu16_pipe_if.sv - handshake and data bundle between alu16_pipe and its neighbours
interface alu16_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );

    // ALU side
    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
endinterface

// File: rtl/alu16_pipe.sv
// rtl/alu16_pipe.sv - two-stage pipelined Hack-style ALU with valid/ready on both sides
module alu16_pipe #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    alu16_pipe_if.slave bus
);
    // ctrl = {zx, nx, zy, ny, f, no}
    logic zx, nx, zy, ny;
    assign {zx, nx, zy, ny} = bus.ctrl[5:2];

    // Operand pre-processing feeding stage 1
    logic [WIDTH-1:0] xz, yz, xp, yp;
    assign xz = zx ? '0 : bus.x;
    assign yz = zy ? '0 : bus.y;
    assign xp = nx ? ~xz : xz;
    assign yp = ny ? ~yz : yz;

    // Stage 1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_xp;
    logic [WIDTH-1:0] s1_yp;
    logic             s1_f;
    logic             s1_no;

    // Handshake: stage 2 can take new data when empty or being drained this cycle
    logic s2_free, advance, accept;
    assign s2_free      = !bus.out_valid || bus.out_ready;
    assign advance      = s1_valid && s2_free;
    assign bus.in_ready = !reset && (!s1_valid || s2_free);
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage 1: capture pre-processed operands on accept, empty when contents leave with no replacement
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_xp    <= '0;
            s1_yp    <= '0;
            s1_f     <= 1'b0;
            s1_no    <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_xp    <= xp;
            s1_yp    <= yp;
            s1_f     <= bus.ctrl[1];
            s1_no    <= bus.ctrl[0];
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Function and output negation; the adder carry out is intentionally dropped
    logic [WIDTH-1:0] sum, r, res;
    assign sum = s1_xp + s1_yp;
    assign r   = s1_f ? sum : (s1_xp & s1_yp);
    assign res = s1_no ? ~r : r;

    // Stage 2: register the result and flags, hold them while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.zr        <= 1'b0;
            bus.ng        <= 1'b0;
        end else if (s2_free) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out <= res;
                bus.zr  <= (res == '0);
                bus.ng  <= res[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_alu16_pipe.sv
// tb/tb_alu16_pipe.sv - randomized and directed self-checking bench for alu16_pipe
module tb_alu16_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu16_pipe_if bus ();

    alu16_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] r;
        int          stamp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   post_rst = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Arithmetic reference: operands as integers, add modulo 2^16
    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        int xv, yv, rv;
        xv = c[5] ? 0 : int'(a);
        if (c[4]) xv = 65535 - xv;
        yv = c[3] ? 0 : int'(b);
        if (c[2]) yv = 65535 - yv;
        rv = c[1] ? (xv + yv) % 65536 : (xv & yv);
        if (c[0]) rv = 65535 - rv;
        return rv[15:0];
    endfunction

    // One clock cycle: drive, check against the in-flight queue, then update the queue at the edge
    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b, input logic [5:0] c,
                        input bit ordy, input bit has_exp, input logic [15:0] exp_r, output bit took);
        bit   e_ready, e_valid;
        exp_t e;
        @(negedge clk);
        reset         = 1'b0;
        bus.in_valid  = v;
        bus.x         = a;
        bus.y         = b;
        bus.ctrl      = c;
        bus.out_ready = ordy;
        #1;
        e_valid = (q.size() > 0) && (q[0].stamp < cyc);
        e_ready = (q.size() < 2) || ordy;
        chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
        if (e_valid) begin
            chk("out", 32'(bus.out), 32'(q[0].r));
            chk("zr", 32'(bus.zr), 32'(q[0].r == 16'h0000));
            chk("ng", 32'(bus.ng), 32'(q[0].r[15]));
        end
        if (post_rst) begin
            chk("rst_out", 32'(bus.out), 32'h0);
            chk("rst_zr", 32'(bus.zr), 32'h0);
            chk("rst_ng", 32'(bus.ng), 32'h0);
            post_rst = 1'b0;
        end
        took = v && e_ready;
        @(posedge clk);
        if (e_valid && ordy) void'(q.pop_front());
        if (took) begin
            e.r     = has_exp ? exp_r : ref_alu(a, b, c);
            e.stamp = cyc + 1;
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic reset_pulse(input bit ordy);
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = ordy;
        #1;
        chk("in_ready_rst", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        q.delete();
        cyc++;
        post_rst = 1'b1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c, input logic [15:0] want);
        bit took;
        int tries;
        tries = 0;
        took  = 1'b0;
        while (!took && tries < 20) begin
            step(1'b1, a, b, c, 1'b1, 1'b1, want, took);
            tries++;
        end
        chk("send_timeout", 32'(took), 32'h1);
    endtask

    task automatic drain();
        bit took;
        int tries;
        tries = 0;
        while (q.size() > 0 && tries < 20) begin
            step(1'b0, 16'h0, 16'h0, 6'h0, 1'b1, 1'b0, 16'h0, took);
            tries++;
        end
        step(1'b0, 16'h0, 16'h0, 6'h0, 1'b1, 1'b0, 16'h0, took);
        chk("drain", 32'(q.size()), 32'h0);
    endtask

    initial begin
        bit took;
        int sent, tries;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.ctrl      = '0;
        bus.out_ready = 1'b0;

        reset_pulse(1'b0);
        reset_pulse(1'b1);

        // Directed values with hand-computed results
        send(16'h0005, 16'h0003, 6'b000010, 16'h0008);
        drain();
        send(16'h0F0F, 16'h00FF, 6'b000000, 16'h000F);
        send(16'h1234, 16'h5678, 6'b101010, 16'h0000);
        send(16'h1234, 16'h5678, 6'b111010, 16'hFFFF);
        send(16'h0003, 16'h0005, 6'b010011, 16'hFFFE);
        send(16'h7FFF, 16'h0001, 6'b000010, 16'h8000);
        drain();

        // Backpressure: four adds, consumer stalled for the first three cycles
        sent = 0;
        tries = 0;
        while (sent < 4 && tries < 20) begin
            step(1'b1, 16'(100 + sent), 16'(sent), 6'b000010, (tries >= 3), 1'b1, 16'(100 + 2 * sent), took);
            if (took) sent++;
            tries++;
        end
        chk("bp_sent", 32'(sent), 32'd4);
        drain();

        // Back-to-back: eight ops on consecutive cycles must all be accepted
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 6'($urandom), 1'b1, 1'b0, 16'h0, took);
            chk("b2b_accept", 32'(took), 32'h1);
        end
        drain();

        // Reset with two operations in flight and the consumer stalled
        step(1'b1, 16'h1111, 16'h2222, 6'b000010, 1'b0, 1'b0, 16'h0, took);
        step(1'b1, 16'h3333, 16'h4444, 6'b000010, 1'b0, 1'b0, 16'h0, took);
        reset_pulse(1'b0);
        step(1'b0, 16'h0, 16'h0, 6'h0, 1'b0, 1'b0, 16'h0, took);
        send(16'h0009, 16'h0001, 6'b000010, 16'h000A);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 6'($urandom),
                 ($urandom % 3) != 0, 1'b0, 16'h0, took);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
